// File: rtl/fdcp_pipe_if.sv
// fdcp_pipe_if: data/valid/occupancy bundle for fdcp_pipe.
// PINJ/PERR exist only when FDCP_PIPE_PARITY_EN is defined.
interface fdcp_pipe_if #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 3
);
   logic                       CE;
   logic [WIDTH-1:0]           D;
   logic                       VLD_IN;
   logic [WIDTH-1:0]           Q;
   logic                       VLD_OUT;
   logic [$clog2(DEPTH+1)-1:0] CNT;
`ifdef FDCP_PIPE_PARITY_EN
   logic                       PINJ;
   logic                       PERR;
   modport master (output CE, D, VLD_IN, PINJ, input Q, VLD_OUT, CNT, PERR);
   modport slave (input CE, D, VLD_IN, PINJ, output Q, VLD_OUT, CNT, PERR);
`else
   modport master (output CE, D, VLD_IN, input Q, VLD_OUT, CNT);
   modport slave (input CE, D, VLD_IN, output Q, VLD_OUT, CNT);
`endif
endinterface

// File: rtl/fdcp_pipe.sv
// fdcp_pipe: DEPTH-stage WIDTH-bit delay line with async CLR/PRE, CE, valid tracking and occupancy count.
// Define FDCP_PIPE_PARITY_EN to add per-stage even parity, sticky PERR output and PINJ inject input.
module fdcp_pipe #(
   parameter int               WIDTH         = 8,
   parameter int               DEPTH         = 3,
   parameter logic [WIDTH-1:0] INIT          = {WIDTH{1'b0}},
   parameter logic [WIDTH-1:0] PRESET_VAL    = {WIDTH{1'b1}},
   parameter bit               IS_C_INVERTED = 1'b1
) (
   input logic        C,
   input logic        CLR,
   input logic        PRE,
   fdcp_pipe_if.slave bus
);
   localparam int CW = $clog2(DEPTH+1);
   logic                        clk_i;
   logic                        pre_i;
   logic [DEPTH-1:0][WIDTH-1:0] stage_q = {DEPTH{INIT}};
   logic [DEPTH-1:0][WIDTH-1:0] stage_d;
   logic [DEPTH-1:0]            vld_q = '0;
   logic [DEPTH-1:0]            vld_d;
   logic [CW-1:0]               cnt_q = '0;
   logic [CW-1:0]               cnt_d;
   assign clk_i = C ^ IS_C_INVERTED;
   // CLR masks PRE so that CLR falling under a held PRE produces a fresh preset event
   assign pre_i = PRE & ~CLR;
   always_comb begin
      stage_d = bus.CE ? (DEPTH*WIDTH)'({stage_q, bus.D}) : stage_q;
      vld_d   = bus.CE ? DEPTH'({vld_q, bus.VLD_IN}) : vld_q;
      cnt_d   = bus.CE ? cnt_q + CW'(bus.VLD_IN) - CW'(vld_q[DEPTH-1]) : cnt_q;
   end
   always_ff @(posedge clk_i or posedge CLR or posedge pre_i) begin
      if (CLR) begin
         stage_q <= '0;
         vld_q   <= '0;
         cnt_q   <= '0;
      end else if (pre_i) begin
         stage_q <= {DEPTH{PRESET_VAL}};
         vld_q   <= '0;
         cnt_q   <= '0;
      end else begin
         stage_q <= stage_d;
         vld_q   <= vld_d;
         cnt_q   <= cnt_d;
      end
   end
   assign bus.Q       = stage_q[DEPTH-1];
   assign bus.VLD_OUT = vld_q[DEPTH-1];
   assign bus.CNT     = cnt_q;
`ifdef FDCP_PIPE_PARITY_EN
   logic [DEPTH-1:0] par_q = {DEPTH{^INIT}};
   logic [DEPTH-1:0] par_d;
   logic             perr_q = 1'b0;
   logic             perr_d;
   always_comb begin
      par_d  = bus.CE ? DEPTH'({par_q, ^bus.D ^ bus.PINJ}) : par_q;
      perr_d = perr_q | (bus.CE & vld_q[DEPTH-1] & (^stage_q[DEPTH-1] != par_q[DEPTH-1]));
   end
   always_ff @(posedge clk_i or posedge CLR or posedge pre_i) begin
      if (CLR) begin
         par_q  <= '0;
         perr_q <= 1'b0;
      end else if (pre_i) begin
         par_q  <= {DEPTH{^PRESET_VAL}};
         perr_q <= 1'b0;
      end else begin
         par_q  <= par_d;
         perr_q <= perr_d;
      end
   end
   assign bus.PERR = perr_q;
`endif
endmodule

// File: tb/tb_fdcp_pipe.sv
// tb_fdcp_pipe: directed vectors for a falling-edge 3-stage pipe and a rising-edge 1-stage pipe,
// cross-checked every half cycle against a capture-history model.
module tb_fdcp_pipe;
   localparam int W = 8, DA = 3, DB = 1;
   logic C = 1'b1;
   logic clr_a = 1'b0, pre_a = 1'b0, clr_b = 1'b0, pre_b = 1'b0;
   int tests = 0, fails = 0;
   fdcp_pipe_if #(.WIDTH(W), .DEPTH(DA)) ia ();
   fdcp_pipe_if #(.WIDTH(W), .DEPTH(DB)) ib ();
   fdcp_pipe #(.WIDTH(W), .DEPTH(DA), .INIT(8'h00), .PRESET_VAL(8'hFF), .IS_C_INVERTED(1'b1))
      dut_a (.C(C), .CLR(clr_a), .PRE(pre_a), .bus(ia));
   fdcp_pipe #(.WIDTH(W), .DEPTH(DB), .INIT(8'h5A), .PRESET_VAL(8'hFF), .IS_C_INVERTED(1'b0))
      dut_b (.C(C), .CLR(clr_b), .PRE(pre_b), .bus(ib));
   always #10 C = ~C;

   task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
      end
   endtask

   logic inj_a;
`ifdef FDCP_PIPE_PARITY_EN
   assign inj_a = ia.PINJ;
`else
   assign inj_a = 1'b0;
`endif

   // Model: an item leaves the pipe exactly DEPTH enabled edges after capture.
   typedef struct packed { logic [W-1:0] d; logic v; logic inj; } ent_t;
   ent_t ha[$];
   logic [W-1:0] fill_a = 8'h00;
   logic perr_a = 1'b0, c_la = 1'b1;
   always @(C or clr_a or pre_a) begin
      if (clr_a || pre_a) begin
         ha.delete();
         fill_a = clr_a ? 8'h00 : 8'hFF;
         perr_a = 1'b0;
      end else if (c_la && !C && ia.CE) begin
         if (ha.size() == DA && ha[0].v && ha[0].inj) perr_a = 1'b1;
         ha.push_back('{d: ia.D, v: ia.VLD_IN, inj: inj_a});
         if (ha.size() > DA) void'(ha.pop_front());
      end
      c_la = C;
   end

   logic [W-1:0] fill_b = 8'h5A, hb_d = 8'h00;
   logic hb_have = 1'b0, hb_v = 1'b0, c_lb = 1'b1;
   always @(C or clr_b or pre_b) begin
      if (clr_b || pre_b) begin
         hb_have = 1'b0;
         fill_b = clr_b ? 8'h00 : 8'hFF;
      end else if (!c_lb && C && ib.CE) begin
         hb_have = 1'b1;
         hb_d = ib.D;
         hb_v = ib.VLD_IN;
      end
      c_lb = C;
   end

   initial forever begin
      int ca;
      @(C);
      #9;
      ca = 0;
      foreach (ha[i]) ca += int'(ha[i].v);
      chk("m_a_q", 32'(ia.Q), 32'(ha.size() == DA ? ha[0].d : fill_a));
      chk("m_a_vld", 32'(ia.VLD_OUT), 32'(ha.size() == DA && ha[0].v));
      chk("m_a_cnt", 32'(ia.CNT), ca);
      chk("m_b_q", 32'(ib.Q), 32'(hb_have ? hb_d : fill_b));
      chk("m_b_vld", 32'(ib.VLD_OUT), 32'(hb_have && hb_v));
      chk("m_b_cnt", 32'(ib.CNT), 32'(hb_have && hb_v));
`ifdef FDCP_PIPE_PARITY_EN
      chk("m_a_perr", 32'(ia.PERR), 32'(perr_a));
      chk("m_b_perr", 32'(ib.PERR), 0);
`endif
   end

   task automatic step_a(input logic [W-1:0] d, input logic v, input logic ce);
      ia.D = d;
      ia.VLD_IN = v;
      ia.CE = ce;
      @(negedge C);
      #2;
   endtask

   typedef struct { logic [W-1:0] d; logic v; logic ce; logic [W-1:0] q; logic vo; int c; } vec_t;
   vec_t tv[15] = '{
      '{8'h01, 1'b1, 1'b1, 8'h00, 1'b0, 1}, '{8'h02, 1'b1, 1'b1, 8'h00, 1'b0, 2},
      '{8'hEE, 1'b1, 1'b0, 8'h00, 1'b0, 2}, '{8'hEE, 1'b1, 1'b0, 8'h00, 1'b0, 2},
      '{8'h03, 1'b1, 1'b1, 8'h01, 1'b1, 3}, '{8'h00, 1'b0, 1'b1, 8'h02, 1'b1, 2},
      '{8'h00, 1'b0, 1'b1, 8'h03, 1'b1, 1}, '{8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 0},
      '{8'h11, 1'b1, 1'b1, 8'h00, 1'b0, 1}, '{8'h22, 1'b1, 1'b1, 8'h00, 1'b0, 2},
      '{8'h33, 1'b1, 1'b1, 8'h11, 1'b1, 3},
      '{8'h44, 1'b1, 1'b1, 8'h00, 1'b0, 1}, '{8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 1},
      '{8'h00, 1'b0, 1'b1, 8'h44, 1'b1, 1}, '{8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 0}};
   int t2_cnt[4] = '{1, 1, 1, 0};
   logic [W-1:0] t2_q[4] = '{8'hFF, 8'hFF, 8'hA5, 8'h00};

   initial begin
      ia.CE = 1'b0; ia.D = '0; ia.VLD_IN = 1'b0;
      ib.CE = 1'b0; ib.D = '0; ib.VLD_IN = 1'b0;
`ifdef FDCP_PIPE_PARITY_EN
      ia.PINJ = 1'b0;
      ib.PINJ = 1'b0;
`endif
      #1;
      chk("pwr_a_q", 32'(ia.Q), 'h00);
      chk("pwr_a_cnt", 32'(ia.CNT), 0);
      chk("pwr_b_q", 32'(ib.Q), 'h5A);
      chk("pwr_b_vld", 32'(ib.VLD_OUT), 0);
      @(negedge C);
      #2 clr_a = 1'b1;
      #1 chk("t1_clr_q", 32'(ia.Q), 'h00);
      chk("t1_clr_cnt", 32'(ia.CNT), 0);
      clr_a = 1'b0;
      #1 clr_a = 1'b1; pre_a = 1'b1;
      #1 chk("t1_both_q", 32'(ia.Q), 'h00);
      chk("t1_both_vld", 32'(ia.VLD_OUT), 0);
      chk("t1_both_cnt", 32'(ia.CNT), 0);
      clr_a = 1'b0;
      #1 chk("t1_pre_q", 32'(ia.Q), 'hFF);
      chk("t1_pre_vld", 32'(ia.VLD_OUT), 0);
      pre_a = 1'b0;
      for (int k = 0; k < 4; k++) begin
         step_a(k == 0 ? 8'hA5 : 8'h00, k == 0, 1'b1);
         chk("t2_cnt", 32'(ia.CNT), t2_cnt[k]);
         chk("t2_vld", 32'(ia.VLD_OUT), 32'(k == 2));
         chk("t2_q", 32'(ia.Q), 32'(t2_q[k]));
         @(posedge C);
         #2 chk("t2_rise_q", 32'(ia.Q), 32'(t2_q[k]));
      end
      for (int i = 0; i < 15; i++) begin
         step_a(tv[i].d, tv[i].v, tv[i].ce);
         chk("t34_q", 32'(ia.Q), 32'(tv[i].q));
         chk("t34_vld", 32'(ia.VLD_OUT), 32'(tv[i].vo));
         chk("t34_cnt", 32'(ia.CNT), tv[i].c);
         if (i == 10) begin
            #3 clr_a = 1'b1;
            #1 chk("t4_clr_q", 32'(ia.Q), 'h00);
            chk("t4_clr_vld", 32'(ia.VLD_OUT), 0);
            chk("t4_clr_cnt", 32'(ia.CNT), 0);
            #1 clr_a = 1'b0;
         end
      end
`ifdef FDCP_PIPE_PARITY_EN
      ia.PINJ = 1'b1;
      step_a(8'h07, 1'b1, 1'b1);
      ia.PINJ = 1'b0;
      for (int k = 0; k < 4; k++) begin
         step_a(8'h00, 1'b0, 1'b1);
         chk("t6_perr", 32'(ia.PERR), 32'(k >= 2));
         if (k == 1) chk("t6_q", 32'(ia.Q), 'h07);
      end
      #3 pre_a = 1'b1;
      #1 chk("t6_pre_perr", 32'(ia.PERR), 0);
      chk("t6_pre_q", 32'(ia.Q), 'hFF);
      #1 pre_a = 1'b0;
`endif
      @(negedge C);
      #2 ib.D = 8'h3C; ib.VLD_IN = 1'b1; ib.CE = 1'b1;
      chk("t5_before_q", 32'(ib.Q), 'h5A);
      @(posedge C);
      #2 chk("t5_q", 32'(ib.Q), 'h3C);
      chk("t5_vld", 32'(ib.VLD_OUT), 1);
      chk("t5_cnt", 32'(ib.CNT), 1);
      ib.D = 8'h00; ib.VLD_IN = 1'b0;
      @(negedge C);
      #2 chk("t5_fall_q", 32'(ib.Q), 'h3C);
      @(posedge C);
      #2 chk("t5_q2", 32'(ib.Q), 'h00);
      chk("t5_cnt2", 32'(ib.CNT), 0);
      #3 pre_b = 1'b1;
      #1 chk("t5_pre_q", 32'(ib.Q), 'hFF);
      clr_b = 1'b1;
      #1 chk("t5_clr_q", 32'(ib.Q), 'h00);
      clr_b = 1'b0;
      #1 chk("t5_rel_q", 32'(ib.Q), 'hFF);
      pre_b = 1'b0;
      @(negedge C);
      #2 $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/fdcp_pipe.md
Name: fdcp_pipe

Overview:
- Parametrised WIDTH-bit, DEPTH-stage register pipeline. It generalises the single-bit D flip-flop with async clear and async preset.
- Adds the following:
  - selectable active clock edge
  - clock enable
  - per-stage valid tracking
  - an occupancy counter
- Used as a retiming/delay primitive in the unisim-style library wherever multi-bit delayed data with async CLR/PRE is needed.

Parameters:
- WIDTH, 8, data width in bits, >=1.
- DEPTH, 3, number of pipeline stages, >=1.
- INIT, {WIDTH{1'b0}}, power-up (time 0) value of every data stage, before any CLR/PRE.
- PRESET_VAL, {WIDTH{1'b1}}, value loaded into every data stage while PRE is high.
- IS_C_INVERTED, 1'b1. 1: stages update on the falling edge of C. 0: stages update on the rising edge of C.

Ports:
- CLR, input, 1: reset. Asynchronous, active-high. Highest priority.
- C, input, 1: clock. Active edge is selected by IS_C_INVERTED.
- PRE, input, 1: asynchronous preset, active-high. Lower priority than CLR.
- CE, input, 1: clock enable, sampled on the active edge.
- D, input, WIDTH: data into stage 0.
- VLD_IN, input, 1: marks D as valid, sampled with D.
- Q, output, WIDTH: data of stage DEPTH-1.
- VLD_OUT, output, 1: valid bit of stage DEPTH-1.
- CNT, output, $clog2(DEPTH+1): number of stages currently holding valid data.

Behaviour:
- Reset:
  - CLR=1 forces, immediately and without waiting for a clock edge: all data stages=0, all valid bits=0, CNT=0.
  - Hence Q=0, VLD_OUT=0.
  - State is held while CLR=1, regardless of PRE/C/CE.
- Preset:
  - CLR=0, PRE=1 forces, immediately: all data stages=PRESET_VAL, all valid bits=0, CNT=0.
  - Held while PRE=1.
- Simultaneous CLR and PRE: CLR wins, so Q=0.
- Release of CLR while PRE=1: outputs go to the preset state in the same delta.
- Power-up, before any reset or clock:
  - data stages=INIT, valid bits=0, CNT=0.
  - INIT has no effect after the first CLR or PRE.
- Active edge with CLR=0, PRE=0, CE=1:
  - stage[0] <= D, vld[0] <= VLD_IN.
  - stage[i] <= stage[i-1] and vld[i] <= vld[i-1] for i=1..DEPTH-1.
  - Data shifts regardless of valid; valid is metadata only.
- Active edge with CE=0: all stages, valid bits and CNT hold.
- Latency: exactly DEPTH enabled active edges from D/VLD_IN sampled to Q/VLD_OUT. The inactive edge and CE=0 edges do not count.
- CNT update on an enabled edge: CNT_next = CNT + VLD_IN - VLD_OUT(pre-edge).
  - Saturating bounds 0..DEPTH. By construction it never exceeds them; no wrap.
  - CNT is registered and changes only on enabled edges or async CLR/PRE.
- DEPTH=1: the block is a WIDTH-bit FDCP with CE and a valid flag. CNT is 1 bit.
- No combinational path from D/VLD_IN/CE to any output. Outputs depend only on state and on the async CLR/PRE.
- Async deassertion of CLR/PRE coincident with an active edge: that edge is not captured. The first capture is the next active edge.

Optional Feature:
- Macro: FDCP_PIPE_PARITY_EN.
- Defined:
  - Each stage carries an extra even-parity bit computed from D at stage 0 and shifted with the data.
  - New output PERR (1 bit, registered) is set to 1 on an enabled edge when VLD_OUT=1 and ^Q != parity of the last stage.
  - PERR is sticky until CLR or PRE, both of which clear it to 0.
  - PRE loads each stage's parity bit with ^PRESET_VAL.
  - Inject input PINJ (1 bit) inverts the stage-0 parity bit when captured, for test.
- Undefined: no parity storage, and no PERR or PINJ ports.

Test Plan:
1. CLR and PRE together
   - Stimulus: WIDTH=8, DEPTH=3, IS_C_INVERTED=1. Pulse CLR mid-low-phase of C with no edge, then assert CLR and PRE together.
   - Required: Q=8'h00, VLD_OUT=0, CNT=0 immediately.
   - Release CLR with PRE still high -> Q=8'hFF.
2. Latency and edge polarity
   - Stimulus: CE=1. Drive D=8'hA5 with VLD_IN=1 for one falling edge, then VLD_IN=0.
   - Required: Q=8'hA5 and VLD_OUT=1 after the 3rd falling edge only, never on rising edges.
   - CNT sequence: 1,1,1,0.
3. Clock enable stall
   - Stimulus: stream 8'h01, 8'h02, 8'h03 with VLD_IN=1, holding CE=0 for 2 edges between the 2nd and 3rd items.
   - Required: Q sequence unchanged (01, 02, 03) with total delay of 3 enabled edges each.
   - CNT holds during the stall; CNT reaches 3 with a continuous stream.
4. Reset mid-operation
   - Stimulus: pipeline full (CNT=3); assert CLR asynchronously between edges.
   - Required: Q=0, VLD_OUT=0, CNT=0 at once.
   - After release, the first output appears 3 enabled edges after the first new valid input.
5. Edge selection and power-up
   - Stimulus: IS_C_INVERTED=0, DEPTH=1.
   - Required: D=8'h3C is captured on the rising edge; Q=8'h3C after 1 rising edge.
   - Before any reset, Q=INIT (set INIT=8'h5A -> Q=8'h5A at time 0).
6. Parity (FDCP_PIPE_PARITY_EN defined)
   - Stimulus: send D=8'h07 with PINJ=1.
   - Required: PERR=1 when the item reaches VLD_OUT=1; stays 1 until PRE is pulsed, then 0.
